// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants, shadow-RAS state type and the link-register test.
package riscv_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } ras_state_t;

    // x1 (ra) and x5 (t0) are the ABI link registers.
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/shadow_ras_if.sv
// riscv_bus view used by the shadow RAS: IF/ID snoop inputs in, stall and security flags out.
interface shadow_ras_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ifid_valid;
    logic [31:0]   ins;
    logic [31:0]   IF_ID_pres_addr;
    logic [31:0]   branoff;
    logic          clr;
    logic          RAS_rdy;
    logic          ras_mismatch;
    logic          ras_overflow;
    logic          ras_underflow;
    logic [31:0]   mismatch_pc;
    logic [CW-1:0] ras_count;

    modport master (
        output ifid_valid, ins, IF_ID_pres_addr, branoff, clr,
        input  RAS_rdy, ras_mismatch, ras_overflow, ras_underflow, mismatch_pc, ras_count
    );

    modport slave (
        input  ifid_valid, ins, IF_ID_pres_addr, branoff, clr,
        output RAS_rdy, ras_mismatch, ras_overflow, ras_underflow, mismatch_pc, ras_count
    );

endinterface

// File: rtl/ras_mem.sv
// Return-address storage: one synchronous write port, one combinational read port, no reset.
module ras_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shadow_ras.sv
// Shadow return-address stack: mirrors call/return pairs seen in IF/ID and stalls the core
// for one cycle per return while the popped link is compared against the resolved target.
module shadow_ras
    import riscv_pkg::*;
#(
    parameter int DEPTH            = 16,
    parameter bit HALT_ON_MISMATCH = 1'b1
) (
    input  logic         clk,
    input  logic         Rst,
    shadow_ras_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ras_state_t    state_q;
    logic          rdy_q;
    logic [AW-1:0] sp_q, sp_d, sp_m1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mism_q, ovf_q, udf_q;
    logic [31:0]   mpc_q;
    logic [31:0]   top_q, target_q, pc_q;

    logic [6:0]    opc;
    logic [4:0]    rd, rs1;
    logic          ev, is_jal, is_jalr, rd_lnk, rs_lnk;
    logic          push, pop, pop_ok, empty, full;
    logic          ovf_ev, udf_ev, chk_fail;
    logic [31:0]   link_addr, mem_rdata;
    logic [AW-1:0] mem_waddr;

    // Decode is only live while IDLE; the core is stalled in CHECK/HALT so nothing is lost.
    assign opc     = bus.ins[6:0];
    assign rd      = bus.ins[11:7];
    assign rs1     = bus.ins[19:15];
    assign ev      = bus.ifid_valid && (state_q == IDLE);
    assign is_jal  = (opc == OPC_JAL);
    assign is_jalr = (opc == OPC_JALR);
    assign rd_lnk  = is_link(rd);
    assign rs_lnk  = is_link(rs1);

    assign push    = ev && (is_jal || is_jalr) && rd_lnk;
    assign pop     = ev && is_jalr && rs_lnk && (!rd_lnk || (rd != rs1));

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign udf_ev  = pop && empty;
    assign ovf_ev  = push && !pop_ok && full;

    assign sp_m1     = sp_q - AW'(1);
    assign link_addr = bus.IF_ID_pres_addr + 32'd4;
    // A coincident pop frees the top slot, so the new link lands there instead of above it.
    assign mem_waddr = pop_ok ? sp_m1 : sp_q;
    assign chk_fail  = (state_q == CHECK) && (top_q != target_q);

    ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (mem_waddr),
        .wdata_i (link_addr),
        .raddr_i (sp_m1),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (pop_ok && !push) begin
            sp_d  = sp_m1;
            cnt_d = cnt_q - CW'(1);
        end else if (push && !pop_ok) begin
            sp_d = sp_q + AW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            sp_q    <= '0;
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            mpc_q   <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_ev | (ovf_q & ~bus.clr);
            udf_q <= udf_ev | (udf_q & ~bus.clr);
            mism_q <= chk_fail | (mism_q & ~bus.clr);
            // Only the first mismatch is recorded; a clr in the same cycle re-arms the capture.
            if (chk_fail && (!mism_q || bus.clr)) begin
                mpc_q <= pc_q;
            end else if (bus.clr) begin
                mpc_q <= '0;
            end

            unique case (state_q)
                IDLE: begin
                    if (pop_ok) begin
                        state_q <= CHECK;
                        rdy_q   <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!chk_fail || !HALT_ON_MISMATCH) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        state_q <= HALT;
                        rdy_q   <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.clr) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pop_ok) begin
            top_q    <= mem_rdata;
            target_q <= bus.branoff;
            pc_q     <= bus.IF_ID_pres_addr;
        end
    end

    assign bus.RAS_rdy       = rdy_q;
    assign bus.ras_mismatch  = mism_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = udf_q;
    assign bus.mismatch_pc   = mpc_q;
    assign bus.ras_count     = cnt_q;

endmodule

// File: tb/tb_shadow_ras.sv
// Scoreboard bench for shadow_ras: stimulus queues hand-computed expectations, a monitor compares them.
module tb_shadow_ras;

    localparam int DEPTH = 4;

    localparam logic [31:0] JAL_X1     = 32'h0000_00EF;  // jal  x1, ...
    localparam logic [31:0] JAL_X5     = 32'h0000_02EF;  // jal  x5, ...
    localparam logic [31:0] RET        = 32'h0000_8067;  // jalr x0, 0(x1)
    localparam logic [31:0] JALR_X1_X5 = 32'h0002_80E7;  // jalr x1, 0(x5)

    localparam int S_RDY = 0, S_MISM = 1, S_OVF = 2, S_UDF = 3, S_MPC = 4, S_CNT = 5;

    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    shadow_ras_if #(.DEPTH(DEPTH)) bus();

    shadow_ras #(
        .DEPTH            (DEPTH),
        .HALT_ON_MISMATCH (1'b1)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_RDY:   return 32'(bus.RAS_rdy);
            S_MISM:  return 32'(bus.ras_mismatch);
            S_OVF:   return 32'(bus.ras_overflow);
            S_UDF:   return 32'(bus.ras_underflow);
            S_MPC:   return bus.mismatch_pc;
            default: return 32'(bus.ras_count);
        endcase
    endfunction

    task automatic chk(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: samples half a cycle after each edge, or right after an async reset assertion.
    initial begin : monitor
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk or negedge Rst);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                a = actual(e.sel);
                n_chk++;
                if (a !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, a, e.exp, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] br);
        bus.ifid_valid      = 1'b1;
        bus.ins             = ins;
        bus.IF_ID_pres_addr = pc;
        bus.branoff         = br;
        step();
        bus.ifid_valid      = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stim
        Rst                 = 1'b0;
        bus.ifid_valid      = 1'b0;
        bus.ins             = 32'h0000_0013;
        bus.IF_ID_pres_addr = '0;
        bus.branoff         = '0;
        bus.clr             = 1'b0;
        repeat (3) @(posedge clk);
        #1 Rst = 1'b1;
        chk(S_RDY, 1, "reset_rdy");
        chk(S_CNT, 0, "reset_count");
        chk(S_MISM, 0, "reset_mismatch");
        chk(S_OVF, 0, "reset_overflow");
        chk(S_UDF, 0, "reset_underflow");
        chk(S_MPC, 0, "reset_mpc");

        // Matching call/return: one stall cycle, no flags.
        issue(JAL_X1, 32'h100, 32'h0);
        chk(S_CNT, 1, "t1_push_count");
        chk(S_RDY, 1, "t1_push_rdy");
        issue(RET, 32'h500, 32'h104);
        chk(S_CNT, 0, "t1_pop_count");
        chk(S_RDY, 0, "t1_check_stall");
        step();
        chk(S_RDY, 1, "t1_stall_one_cycle");
        chk(S_MISM, 0, "t1_no_mismatch");

        // Mismatching return halts until clr.
        issue(JAL_X1, 32'h100, 32'h0);
        issue(RET, 32'h600, 32'h200);
        chk(S_RDY, 0, "t2_check_stall");
        step();
        chk(S_RDY, 0, "t2_halt_rdy");
        chk(S_MISM, 1, "t2_mismatch_set");
        chk(S_MPC, 32'h600, "t2_mismatch_pc");
        step();
        chk(S_RDY, 0, "t2_halt_holds");
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk(S_RDY, 1, "t2_clr_rdy");
        chk(S_MISM, 0, "t2_clr_mismatch");
        chk(S_MPC, 0, "t2_clr_mpc");

        // DEPTH+1 nested calls overflow; the newest DEPTH links come back in order.
        for (int i = 0; i <= DEPTH; i++) begin
            issue(JAL_X1, 32'(i * 16), 32'h0);
            if (i == DEPTH - 1) chk(S_OVF, 0, "t3_full_no_ovf");
        end
        chk(S_CNT, DEPTH, "t3_count_saturated");
        chk(S_OVF, 1, "t3_overflow");
        for (int k = 0; k < DEPTH; k++) begin
            issue(RET, 32'h800, 32'(32'h44 - 32'(k * 16)));
            chk(S_CNT, 32'(DEPTH - 1 - k), "t3_pop_count");
            chk(S_RDY, 0, "t3_pop_stall");
            step();
            chk(S_RDY, 1, "t3_pop_resume");
            chk(S_MISM, 0, "t3_pop_match");
        end
        issue(RET, 32'h800, 32'h0);
        chk(S_CNT, 0, "t3_empty_count");
        chk(S_RDY, 1, "t3_underflow_no_stall");
        chk(S_UDF, 1, "t3_underflow");
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk(S_OVF, 0, "t3_clr_overflow");
        chk(S_UDF, 0, "t3_clr_underflow");

        // Co-routine swap: pop checked, 0x304 pushed into freed slot.
        issue(JAL_X5, 32'h200, 32'h0);
        chk(S_CNT, 1, "t4_push_x5");
        issue(JALR_X1_X5, 32'h300, 32'h204);
        chk(S_CNT, 1, "t4_swap_count");
        chk(S_RDY, 0, "t4_swap_stall");
        step();
        chk(S_RDY, 1, "t4_swap_resume");
        chk(S_MISM, 0, "t4_swap_match");
        issue(RET, 32'h900, 32'h304);
        chk(S_CNT, 0, "t4_ret_count");
        step();
        chk(S_MISM, 0, "t4_ret_match_304");

        // ifid_valid held through CHECK with a call: ignored.
        issue(JAL_X1, 32'h100, 32'h0);
        bus.ifid_valid      = 1'b1;
        bus.ins             = RET;
        bus.IF_ID_pres_addr = 32'h500;
        bus.branoff         = 32'h104;
        step();
        chk(S_CNT, 0, "t6_pop_count");
        chk(S_RDY, 0, "t6_check_stall");
        bus.ins             = JAL_X1;
        bus.IF_ID_pres_addr = 32'h700;
        step();
        bus.ifid_valid = 1'b0;
        chk(S_CNT, 0, "t6_no_push_in_check");
        chk(S_RDY, 1, "t6_resume");

        // Underflow coinciding with clr: the flag still sets.
        bus.clr = 1'b1;
        issue(RET, 32'hA00, 32'h0);
        bus.clr = 1'b0;
        chk(S_UDF, 1, "t7_udf_beats_clr");
        chk(S_RDY, 1, "t7_udf_no_stall");

        // Async reset mid-CHECK.
        issue(JAL_X1, 32'h100, 32'h0);
        issue(RET, 32'h500, 32'h200);
        chk(S_RDY, 0, "t5_in_check");
        @(negedge clk);
        #3;
        chk(S_RDY, 1, "t5_async_rdy");
        chk(S_CNT, 0, "t5_async_count");
        chk(S_MISM, 0, "t5_async_mismatch");
        chk(S_UDF, 0, "t5_async_underflow");
        chk(S_MPC, 0, "t5_async_mpc");
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        step();
        chk(S_RDY, 1, "t5_after_release_rdy");
        chk(S_MISM, 0, "t5_after_release_mismatch");

        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/shadow_ras.md
Name: shadow_ras

Overview:
- Hardware shadow return-address stack beside the core. Watches calls and returns leaving IF/ID and checks each return target against the address saved at its call.
- Drives the core's RAS_rdy input, which gates PC_En. The core stalls for one cycle while each return is checked, and stays stalled on a mismatch when halting is enabled.
- Sits directly downstream of the core on the riscv_bus: consumes ins, IF_ID_pres_addr and branoff; produces RAS_rdy plus sticky security flags.

Parameters:
- DEPTH, 16, number of stack entries; power of two, at least 2.
- HALT_ON_MISMATCH, 1, when 1 a mismatch holds RAS_rdy low until clr.

Ports:
- clk  in  1  system clock.
- Rst  in  1  reset; asynchronous, active-low.
- ifid_valid  in  1  one-cycle pulse when a new instruction is present in IF/ID.
- ins  in  32  IF/ID instruction.
- IF_ID_pres_addr  in  32  PC of the IF/ID instruction.
- branoff  in  32  resolved jump target of the IF/ID instruction.
- clr  in  1  clears the sticky flags and leaves HALT.
- RAS_rdy  out  1  1 = core may advance.
- ras_mismatch  out  1  sticky: a return target differed from the saved address.
- ras_overflow  out  1  sticky: push when full.
- ras_underflow  out  1  sticky: pop when empty.
- mismatch_pc  out  32  PC of the first mismatching return.
- ras_count  out  $clog2(DEPTH)+1  valid entries.

Behaviour:
- Reset: all outputs 0 except RAS_rdy=1; state IDLE; sp=0; the storage array is not reset.
- Decode (combinational, qualified by ifid_valid && state==IDLE):
  - jal = ins[6:0]==7'b1101111.
  - jalr = ins[6:0]==7'b1100111.
  - link(r) = r==1 || r==5.
  - push = (jal||jalr) && link(rd), with rd=ins[11:7].
  - pop = jalr && !link(rd) && link(rs1), with rs1=ins[19:15].
  - jalr with link(rd) && link(rs1): if rd!=rs1, pop then push; if rd==rs1, push only.
- Push: next edge writes IF_ID_pres_addr+4 (32-bit wrap) at entry sp; sp=(sp+1) mod DEPTH; ras_count += 1.
  - Full (ras_count==DEPTH): overwrite the oldest entry, ras_count stays DEPTH, set ras_overflow.
- Pop:
  - Empty: no check, no state change, set ras_underflow, RAS_rdy stays 1.
  - Otherwise, next edge: capture top=entry[sp-1], target=branoff, pc=IF_ID_pres_addr; sp -= 1; ras_count -= 1; go to CHECK.
- Pop+push in the same cycle: the compare uses the popped top; the new link is written into the freed slot; ras_count is unchanged; state goes to CHECK.
- States:
  - IDLE: RAS_rdy=1.
  - CHECK: RAS_rdy=0 for exactly one cycle.
    - top==target: go to IDLE.
    - Otherwise: set ras_mismatch; load mismatch_pc only if ras_mismatch was 0; go to HALT if HALT_ON_MISMATCH, else IDLE.
  - HALT: RAS_rdy=0; leave to IDLE only on clr.
- ifid_valid in CHECK or HALT is ignored; the core is stalled, so no event is lost.
- clr:
  - Clears ras_mismatch, ras_overflow, ras_underflow and mismatch_pc at the next edge; HALT goes to IDLE.
  - Stack contents and ras_count are kept.
  - A flag event in the same cycle as clr wins: the flag ends up set.
- Latency: push visible to a following pop one cycle later (back-to-back push then pop checks the just-pushed value; forward if needed). Every successful return costs 1 stall cycle.
- Reset asserted mid-CHECK or mid-HALT returns to IDLE immediately, asynchronously, with RAS_rdy=1.

Decomposition:
- riscv_pkg (shared):
  - OPC_JAL, OPC_JALR constants.
  - ras_state_t enum {IDLE, CHECK, HALT}.
  - is_link() function.
- Sub-module ras_mem: DEPTH x 32 register array with one write port and one combinational read port, addressed by sp/sp-1.
- The FSM and flags stay in shadow_ras.

Test Plan:
- Call at PC 0x100 (jal x1), then return (jalr x0,0(x1)) with branoff=0x104 -> ras_count 1→0; RAS_rdy low exactly 1 cycle; no flags.
- Same call, then return with branoff=0x200 -> ras_mismatch=1, mismatch_pc=return PC, RAS_rdy stays 0 (HALT); clr pulse -> RAS_rdy=1, flags 0.
- DEPTH+1 nested calls at PCs 0x0,0x10,… -> ras_overflow=1, ras_count=DEPTH; DEPTH returns match the newest DEPTH links; one more return -> ras_underflow=1, no stall.
- jalr x1,0(x5) at 0x300 with x5 link on the stack -> pop is checked, 0x304 is pushed, ras_count unchanged.
- Rst driven low mid-CHECK -> RAS_rdy=1 immediately (asynchronously), all outputs 0, ras_count 0.
- ifid_valid held high during CHECK with a call instruction -> no extra push; ras_count unchanged.
